// File: rtl/bit_serial_pkg.sv
// Shared constants and state encoding for the bit-serial operand path and the
// adder tree it feeds.
package bit_serial_pkg;

    localparam int NUM_INPUTS = 8;
    localparam int IN_WIDTH   = 8;
    localparam int FRAME_LEN  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serial_lane.sv
// One serial lane: parallel load, then arithmetic right shift so the sign bit
// keeps repeating once the operand's own bits are exhausted.
module bit_serial_lane
    import bit_serial_pkg::*;
#(
    parameter int LANE_WIDTH = IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [LANE_WIDTH-1:0] load_data,
    output logic                  ser_bit
);

    logic [LANE_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {sr[LANE_WIDTH-1], sr[LANE_WIDTH-1:1]};
        end
    end

    assign ser_bit = sr[0];

endmodule

// File: rtl/bit_serial_operand_serializer.sv
// Turns parallel signed operand beats into LSB-first, sign-extended serial
// frames with a frame-boundary clean strobe; a shadow beat gives gapless frames.
module bit_serial_operand_serializer
    import bit_serial_pkg::*;
#(
    parameter int NUM_INPUTS = bit_serial_pkg::NUM_INPUTS,
    parameter int IN_WIDTH   = bit_serial_pkg::IN_WIDTH,
    parameter int FRAME_LEN  = bit_serial_pkg::FRAME_LEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]          out_bits,
    output logic                           clean,
    output logic                           busy,
    output state_t                         dbg_state
);

    localparam int W     = NUM_INPUTS * IN_WIDTH;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [W-1:0]        shadow;
    logic                shadow_full, shadow_full_n, shadow_load;
    logic                lane_load, lane_shift, load_from_shadow;
    logic [W-1:0]        load_data;
    logic [NUM_INPUTS-1:0] lane_bits;
    logic                xfer, last;

    // Handshake: a beat moves on a rising edge with in_valid && in_ready; the
    // source holds in_valid/in_data stable until then. in_ready is low in reset.
    assign in_ready = reset & ~shadow_full;
    assign xfer     = in_valid & in_ready;
    assign last     = (state == ST_SHIFT) && (cnt == CNT_LAST);

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        shadow_full_n    = shadow_full;
        shadow_load      = 1'b0;
        lane_load        = 1'b0;
        lane_shift       = 1'b0;
        load_from_shadow = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    lane_load = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last) begin
                    cnt_n      = cnt + CNT_W'(1);
                    lane_shift = 1'b1;
                    if (xfer) begin
                        shadow_load   = 1'b1;
                        shadow_full_n = 1'b1;
                    end
                end else if (shadow_full) begin
                    lane_load        = 1'b1;
                    load_from_shadow = 1'b1;
                    cnt_n            = '0;
                    shadow_full_n    = 1'b0;
                end else if (xfer) begin
                    // Beat arriving on the final bit goes straight to the lanes.
                    lane_load = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shadow_full <= 1'b0;
            shadow      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shadow_full <= shadow_full_n;
            if (shadow_load) begin
                shadow <= in_data;
            end
        end
    end

    assign load_data = load_from_shadow ? shadow : in_data;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
        bit_serial_lane #(
            .LANE_WIDTH(IN_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (lane_load),
            .shift    (lane_shift),
            .load_data(load_data[k*IN_WIDTH +: IN_WIDTH]),
            .ser_bit  (lane_bits[k])
        );
    end

    assign busy      = (state == ST_SHIFT);
    assign clean     = last;
    assign out_bits  = busy ? lane_bits : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_bit_serial_operand_serializer.sv
// Bench for the bit-serial operand serializer: a beat-queue reference model,
// a frame deserializer that sums lanes, and directed scenarios.
module tb_bit_serial_operand_serializer;
    import bit_serial_pkg::*;

    localparam int N  = NUM_INPUTS;
    localparam int IW = IN_WIDTH;
    localparam int FL = FRAME_LEN;
    localparam int W  = N * IW;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [N-1:0] out_bits;
    logic         clean;
    logic         busy;
    state_t       dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    bit_serial_operand_serializer #(
        .NUM_INPUTS(N),
        .IN_WIDTH  (IW),
        .FRAME_LEN (FL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_bits (out_bits),
        .clean    (clean),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // At most one beat may wait behind the frame being emitted; frames play out
    // back to back, each FL cycles long, sign-extended LSB first.
    logic [W-1:0] pending[$];
    logic [W-1:0] m_frame = '0;
    bit           m_active = 1'b0;
    int           m_idx = 0;

    always @(posedge clk) begin
        bit xfer_m;
        if (!reset) begin
            m_active = 1'b0;
            m_idx    = 0;
            pending.delete();
        end else begin
            xfer_m = in_valid && (pending.size() == 0);
            if (m_active) begin
                m_idx++;
                if (m_idx == FL) m_active = 1'b0;
            end
            if (xfer_m) pending.push_back(in_data);
            if (!m_active && pending.size() > 0) begin
                m_frame  = pending.pop_front();
                m_active = 1'b1;
                m_idx    = 0;
            end
        end
    end

    function automatic logic [N-1:0] exp_bits(input logic [W-1:0] f, input int idx);
        logic [N-1:0] r;
        int b;
        r = '0;
        b = (idx < IW) ? idx : IW - 1;
        for (int k = 0; k < N; k++) r[k] = f[k*IW + b];
        return r;
    endfunction

    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = reset && (pending.size() == 0);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_active));
        chk("clean", 64'(clean), 64'(m_active && (m_idx == FL - 1)));
        chk("out_bits", 64'(out_bits), 64'(m_active ? exp_bits(m_frame, m_idx) : '0));
        chk("dbg_state", 64'(dbg_state), 64'(m_active ? ST_SHIFT : ST_IDLE));
    end

    // ---------------- scoreboard: deserialize frames, sum lanes ----------------
    logic [31:0]   exp_q[$];
    logic [FL-1:0] lane0_q[$];
    logic [FL-1:0] lane1_q[$];
    logic [FL-1:0] acc[N];
    int            c_idx = 0;
    int            frames_done = 0;

    always @(negedge clk) begin
        logic [FL-1:0] sum;
        if (!reset) begin
            c_idx = 0;
            exp_q.delete();
        end else if (busy) begin
            if (c_idx < FL) for (int k = 0; k < N; k++) acc[k][c_idx] = out_bits[k];
            if (clean) begin
                sum = '0;
                for (int k = 0; k < N; k++) sum = sum + acc[k];
                frames_done++;
                lane0_q.push_back(acc[0]);
                lane1_q.push_back(acc[1]);
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL frame_sum: got frame %0h expected no frame", sum);
                end else begin
                    chk("frame_sum", 64'(sum), 64'(exp_q.pop_front()));
                end
                c_idx = 0;
            end else begin
                c_idx++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] lane_sum(input logic [W-1:0] d);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'($signed(d[k*IW +: IW]));
        return 32'(s);
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [31:0] exp_sum, output int acc_cyc);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done && t < 200) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                t++;
            end
        end
        n_total++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
        end
        exp_q.push_back(exp_sum);
        acc_cyc = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_active || pending.size() > 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (t >= 300) begin
            n_bad++;
            $display("FAIL idle_timeout: got still busy, expected idle within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack_ab(input logic [IW-1:0] a, input logic [IW-1:0] b);
        return {a, b, a, b, b, b, b, a};
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0] d;
        int ca, cb, cc, cd, ce, tmp, f0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_clean", 64'(clean), 64'(0));
        chk("rst_out_bits", 64'(out_bits), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single beat, every lane -10.
        d = {N{8'hF6}};
        send(d, lane_sum(d), tmp);
        in_valid = 1'b0;
        wait_idle();
        chk("lane0_minus10", 64'(lane0_q[$]), 64'(32'hFFFF_FFF6));
        chk("frames_single", 64'(frames_done), 64'(1));
        chk("sum_minus10", 64'(lane_sum(d)), 64'(32'hFFFF_FFB0));

        // Extremes: 127 on even lanes, -128 on odd lanes.
        for (int k = 0; k < N; k++) d[k*IW +: IW] = (k % 2 == 1) ? 8'h80 : 8'h7F;
        send(d, lane_sum(d), tmp);
        in_valid = 1'b0;
        wait_idle();
        chk("lane_127", 64'(lane0_q[$]), 64'(32'h0000_007F));
        chk("lane_m128", 64'(lane1_q[$]), 64'(32'hFFFF_FF80));

        // in_valid held across three beats.
        d = 64'h0123_4567_89AB_CDEF;
        send(d, lane_sum(d), ca);
        d = 64'hFEDC_BA98_7654_3210;
        send(d, lane_sum(d), cb);
        d = 64'h7F80_55AA_0001_FFFE;
        send(d, lane_sum(d), cc);
        in_valid = 1'b0;
        chk("b_after_a", 64'(cb - ca), 64'(1));
        chk("c_after_a", 64'(cc - ca), 64'(FL + 1));
        wait_idle();

        // Bypass: offer a beat exactly in the last-bit cycle with shadow empty.
        d = {N{8'h35}};
        send(d, lane_sum(d), cd);
        in_valid = 1'b0;
        repeat (FL - 1) @(posedge clk);
        #1;
        d = {N{8'hC3}};
        send(d, lane_sum(d), ce);
        in_valid = 1'b0;
        chk("bypass_gap", 64'(ce - cd), 64'(FL));
        @(negedge clk);
        chk("bypass_ready", 64'(in_ready), 64'(1));
        wait_idle();

        // Reset at cnt=12 with the shadow full.
        d = {N{8'h5A}};
        send(d, lane_sum(d), tmp);
        d = {N{8'hA5}};
        send(d, lane_sum(d), tmp);
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        f0 = frames_done;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_bits", 64'(out_bits), 64'(0));
        chk("midrst_clean", 64'(clean), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ready", 64'(in_ready), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 64'(in_ready), 64'(1));
        repeat (2 * FL) @(posedge clk);
        #1;
        chk("no_stale_frame", 64'(frames_done), 64'(f0));

        // Sweep a, b over -10..9 on lanes {a,b,a,b,b,b,b,a}: sum = 3a + 5b.
        f0 = frames_done;
        for (int a = -10; a <= 9; a++) begin
            for (int b = -10; b <= 9; b++) begin
                send(pack_ab(8'(a), 8'(b)), 32'(3 * a + 5 * b), tmp);
            end
        end
        in_valid = 1'b0;
        wait_idle();
        chk("sweep_frames", 64'(frames_done - f0), 64'(400));
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_operand_serializer.md
BIT_SERIAL_OPERAND_SERIALIZER -- requirements
Module: bit_serial_operand_serializer

Interface
REQ-001 Parameter NUM_INPUTS, default 8: number of serial lanes; matches the adder tree input count.
REQ-002 Parameter IN_WIDTH, default 8: two's-complement width of each parallel operand.
REQ-003 Parameter FRAME_LEN, default 32: bits per serial frame, matching the adder tree result width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 in_valid  input  1  parallel operand beat offered.
REQ-007 in_ready  output  1  beat can be accepted this cycle.
REQ-008 in_data  input  NUM_INPUTS*IN_WIDTH  lane k operand at bits [k*IN_WIDTH +: IN_WIDTH], signed.
REQ-009 out_bits  output  NUM_INPUTS  one serial bit per lane, LSB first, driving the adder tree inputs.
REQ-010 clean  output  1  frame-boundary strobe, driving the adder tree clean.
REQ-011 busy  output  1  a frame is being shifted out.

Function
REQ-012 Handshake: a beat transfers on a rising edge when in_valid=1 and in_ready=1; once asserted, in_valid and in_data SHALL stay stable until that transfer.
REQ-013 Storage: one active frame register plus one shadow register; in_ready = !shadow_full, combinational.
REQ-014 States: IDLE and SHIFT, with bit counter cnt in the range 0..FRAME_LEN-1.
REQ-015 IDLE + transfer at edge E: load the beat into the active register, set cnt=0 and enter SHIFT; out_bits carries bit 0 in the cycle following E, with no further latency.
REQ-016 SHIFT: out_bits[k] = lane k bit min(cnt, IN_WIDTH-1); bits at and beyond IN_WIDTH-1 repeat the sign bit.
REQ-017 SHIFT: cnt increments by 1 each cycle.
REQ-018 SHIFT: a transfer during SHIFT fills the shadow register.
REQ-019 clean = 1 only in the SHIFT cycle where cnt = FRAME_LEN-1; otherwise 0.
REQ-020 At the edge ending cnt = FRAME_LEN-1, shadow full: move the shadow to active, set cnt=0 and mark the shadow empty; this gives back-to-back frames with zero gap cycles.
REQ-021 At the edge ending cnt = FRAME_LEN-1, shadow empty with a simultaneous transfer: bypass the beat straight to active and set cnt=0.
REQ-022 At the edge ending cnt = FRAME_LEN-1, shadow empty with no transfer: go to IDLE.
REQ-023 IDLE outputs: out_bits=0, clean=0, busy=0.
REQ-024 busy = 1 exactly when the state is SHIFT.
REQ-025 in_data values are treated as signed; sign extension holds for every value from -2^(IN_WIDTH-1) to 2^(IN_WIDTH-1)-1.

Reset
REQ-026 While reset=0 at a rising edge: state IDLE, cnt=0, shadow empty, out_bits=0, clean=0, busy=0; in_ready is held 0 while reset is low.
REQ-027 Reset mid-frame abandons the active frame and the shadow contents with no partial-frame clean.
REQ-028 in_ready = 1 in the first cycle after reset returns to 1.

Structure
REQ-029 Shared package bit_serial_pkg SHALL hold NUM_INPUTS, IN_WIDTH, FRAME_LEN and the IDLE/SHIFT state enum; the adder tree and its bench SHALL use the same package.
REQ-030 One sub-module bit_serial_lane SHALL be instantiated NUM_INPUTS times: a per-lane shift register with sign-bit hold, plus load and shift enables.
REQ-031 cnt, the state machine and the shadow register SHALL be shared across lanes in the top level.

Verification
REQ-032 Single beat, all lanes = -10 (0xF6): each out_bits[k] reads 0,1,1,0,1,1,1,1 then 1 for 24 cycles; clean is high only in cycle 31; then IDLE with zeros.
REQ-033 Lane values 127 and -128: 127 serialises as 1×7, then 0 for 25 cycles; -128 serialises as 0×7, then 1 for 25 cycles.
REQ-034 in_valid held high with three beats A, B, C:
- A and B are accepted in consecutive cycles.
- in_ready drops until the cycle after A's cnt=31.
- B's bit 0 immediately follows A's bit 31.
- C is held stable and is accepted when in_ready reasserts.
REQ-035 Bypass: a beat is offered exactly in the cnt=31 cycle with the shadow empty -> the next frame starts with no gap and the shadow stays empty.
REQ-036 reset=0 applied at cnt=12 with the shadow full -> next cycle out_bits=0, clean=0, busy=0; in_ready=1 after release; no stale frame is emitted.
REQ-037 End-to-end with adder_tree, sweeping a, b over -10..9 on lanes {a,b,a,b,b,b,b,a}: every 32-bit serial result equals 3a+5b, with back-to-back frames.
